// File: rtl/reg_bank_param.sv
// reg_bank_param: parametrised DEPTH x WIDTH register bank for the decode stage.
// Two combinational read ports, one synchronous write port, optional hardwired
// zero register, optional write-to-read forwarding, a per-register pending
// scoreboard for hazard detection and a DEPTH-cycle bulk-clear sequencer.
module reg_bank_param #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   WriteFlag,
  input  logic [AW-1:0]          DirW,
  input  logic [WIDTH-1:0]       WriteData,
  output logic                   WriteReady,
  input  logic [AW-1:0]          DirA,
  input  logic [AW-1:0]          DirB,
  output logic [WIDTH-1:0]       OutputA,
  output logic [WIDTH-1:0]       OutputB,
  input  logic                   IssueFlag,
  input  logic [AW-1:0]          DirI,
  output logic                   PendA,
  output logic                   PendB,
  input  logic                   ClearReq,
  output logic                   ClearBusy,
  output logic                   ClearDone,
  output logic [DEPTH*WIDTH-1:0] DebugAll
);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t           state;
  state_t           nextState;
  logic [AW-1:0]    clearCnt;
  logic             clearStart;
  logic [WIDTH-1:0] rf [DEPTH];
  logic [DEPTH-1:0] pend;
  logic [DEPTH-1:0] pendNext;
  logic             writeAccept;
  logic             issueAccept;
  logic             writeStore;

  // Writes and issues are only taken while the sequencer is not clearing.
  assign WriteReady  = !ClearBusy;
  assign writeAccept = WriteFlag && WriteReady;
  assign issueAccept = IssueFlag && WriteReady;
  // A write to the hardwired zero register is accepted but never stored.
  assign writeStore  = writeAccept && !(ZERO_REG && (DirW == '0));

  // Clear sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nextState;
  end

  // Clear sequencer next state and status outputs.
  always_comb begin
    nextState  = state;
    ClearBusy  = 1'b0;
    ClearDone  = 1'b0;
    clearStart = 1'b0;
    case (state)
      IDLE: begin
        if (ClearReq) begin
          nextState  = CLEAR;
          clearStart = 1'b1;
        end
      end
      CLEAR: begin
        ClearBusy = 1'b1;
        if (clearCnt == AW'(DEPTH - 1)) begin
          ClearDone = 1'b1;
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // Clear counter walks every register index once per sequence; it wraps
  // back to zero on the final cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         clearCnt <= '0;
    else if (clearStart) clearCnt <= '0;
    else if (ClearBusy)  clearCnt <= clearCnt + AW'(1);
  end

  // Register storage: the clear sequencer owns the array while busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) rf[i] <= '0;
    end else if (ClearBusy) begin
      rf[clearCnt] <= '0;
    end else if (writeStore) begin
      rf[DirW] <= WriteData;
    end
  end

  // Scoreboard update: a completing write clears, an issue sets (set wins on
  // the same address), entering a clear wipes everything.
  always_comb begin
    pendNext = pend;
    if (clearStart) begin
      pendNext = '0;
    end else begin
      if (writeAccept) pendNext[DirW] = 1'b0;
      if (issueAccept) pendNext[DirI] = 1'b1;
    end
    if (ZERO_REG) pendNext[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pend <= '0;
    else        pend <= pendNext;
  end

  // Pending lookups reflect only the registered scoreboard.
  assign PendA = pend[DirA];
  assign PendB = pend[DirB];

  // Read port A with zero register and optional same-cycle forwarding.
  always_comb begin
    OutputA = rf[DirA];
    if (ZERO_REG && (DirA == '0))
      OutputA = '0;
    else if (BYPASS && writeAccept && (DirW == DirA))
      OutputA = WriteData;
  end

  // Read port B with zero register and optional same-cycle forwarding.
  always_comb begin
    OutputB = rf[DirB];
    if (ZERO_REG && (DirB == '0))
      OutputB = '0;
    else if (BYPASS && writeAccept && (DirW == DirB))
      OutputB = WriteData;
  end

  // Flattened view of the whole array for the debug/display logic.
  for (genvar g = 0; g < DEPTH; g++) begin : gDebug
    assign DebugAll[g*WIDTH +: WIDTH] = rf[g];
  end

endmodule
